// File: rtl/rf_scoreboard.sv
// rf_scoreboard: dual write-back register file with bypassed combinational reads
// and a per-register busy scoreboard; x0 is hardwired to zero.
module rf_scoreboard #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NRD = 2,
   parameter int PRESET_IDX = 6,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [XLEN-1:0]     preset_val,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [XLEN-1:0]     wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [XLEN-1:0]     wr1_data,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [AW:0]         busy_cnt
);
   localparam logic [AW-1:0] PIDX = AW'(PRESET_IDX);
   logic [XLEN-1:0] r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [AW:0] r_cnt;
   logic [AW:0] w_cnt;
   // Issue outranks write-back: the newly issued producer supersedes the retiring one.
   always_comb begin
      w_busy_nxt = '0;
      w_cnt = '0;
      for (int r = 1; r < NREGS; r++) begin
         w_busy_nxt[r] = flush ? 1'b0 :
                         (iss_en && iss_addr == AW'(r)) ? 1'b1 :
                         ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r))) ? 1'b0 :
                         r_busy[r];
         w_cnt = w_cnt + (AW+1)'(w_busy_nxt[r]);
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++)
            r_regs[r] <= (r == PRESET_IDX) ? preset_val : '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (wr1_en && wr1_addr == AW'(r)) r_regs[r] <= wr1_data;
            else if (wr0_en && wr0_addr == AW'(r)) r_regs[r] <= wr0_data;
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= '0;
         r_cnt <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt <= w_cnt;
      end
   end
   assign busy_cnt = r_cnt;
   // During reset the preset register follows preset_val combinationally and bypass is suppressed.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] w_a;
      logic w_h0, w_h1;
      assign w_a = rd_addr[k*AW +: AW];
      assign w_h0 = rst && wr0_en && wr0_addr == w_a;
      assign w_h1 = rst && wr1_en && wr1_addr == w_a;
      assign rd_data[k*XLEN +: XLEN] = (w_a == '0) ? '0 :
                                       w_h1 ? wr1_data :
                                       w_h0 ? wr0_data :
                                       (!rst && w_a == PIDX) ? preset_val :
                                       r_regs[w_a];
      assign rd_busy[k] = (w_a != '0) && r_busy[w_a] && !w_h0 && !w_h1;
   end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed vector table plus hand sequences for reset and async reset.
module tb_rf_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] preset_val;
   logic        wr0_en, wr1_en, iss_en, flush;
   logic [4:0]  wr0_addr, wr1_addr, iss_addr;
   logic [31:0] wr0_data, wr1_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [5:0]  busy_cnt;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rf_scoreboard dut (
      .clk(clk), .rst(rst), .preset_val(preset_val),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
   );

   typedef struct {
      logic        w0e;
      logic [4:0]  w0a;
      logic [31:0] w0d;
      logic        w1e;
      logic [4:0]  w1a;
      logic [31:0] w1d;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        ie;
      logic [4:0]  ia;
      logic        fl;
      logic [31:0] ed0;
      logic [31:0] ed1;
      logic [1:0]  eb;
      logic [5:0]  ec;
   } vec_t;

   vec_t v [17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wr0_en = 0; wr0_addr = 0; wr0_data = 0;
      wr1_en = 0; wr1_addr = 0; wr1_data = 0;
      iss_en = 0; iss_addr = 0; flush = 0;
   endtask

   initial begin
      v[0]  = '{1,5,32'hDEADBEEF, 0,0,0,          5,6,  0,0,0, 32'hDEADBEEF,32'h14,       2'b00,0};
      v[1]  = '{0,0,0,            0,0,0,          5,0,  0,0,0, 32'hDEADBEEF,0,            2'b00,0};
      v[2]  = '{0,0,0,            1,0,32'hFFFF,   0,0,  0,0,0, 0,0,                       2'b00,0};
      v[3]  = '{1,7,32'h1111,     1,7,32'h2222,   7,5,  0,0,0, 32'h2222,32'hDEADBEEF,     2'b00,0};
      v[4]  = '{0,0,0,            0,0,0,          7,0,  0,0,0, 32'h2222,0,                2'b00,0};
      v[5]  = '{0,0,0,            0,0,0,          3,7,  1,3,0, 0,32'h2222,                2'b00,1};
      v[6]  = '{0,0,0,            0,0,0,          3,0,  0,0,0, 0,0,                       2'b01,1};
      v[7]  = '{1,3,32'h33,       0,0,0,          3,3,  0,0,0, 32'h33,32'h33,             2'b00,0};
      v[8]  = '{0,0,0,            0,0,0,          3,0,  0,0,0, 32'h33,0,                  2'b00,0};
      v[9]  = '{0,0,0,            1,3,32'h44,     3,0,  1,3,0, 32'h44,0,                  2'b00,1};
      v[10] = '{0,0,0,            0,0,0,          3,0,  0,0,0, 32'h44,0,                  2'b01,1};
      v[11] = '{1,3,32'h55,       0,0,0,          3,0,  0,0,0, 32'h55,0,                  2'b00,0};
      v[12] = '{0,0,0,            0,0,0,          1,2,  1,1,0, 0,0,                       2'b00,1};
      v[13] = '{0,0,0,            0,0,0,          1,2,  1,2,0, 0,0,                       2'b01,2};
      v[14] = '{0,0,0,            0,0,0,          1,2,  1,4,0, 0,0,                       2'b11,3};
      v[15] = '{0,0,0,            0,0,0,          4,8,  1,8,1, 0,0,                       2'b01,0};
      v[16] = '{0,0,0,            0,0,0,          4,8,  0,0,0, 0,0,                       2'b00,0};

      idle();
      rst = 0;
      preset_val = 32'hA;
      rd_addr = {5'd1, 5'd6};
      #2;
      check("rst_reg6", rd_data[31:0], 32'hA);
      check("rst_reg1", rd_data[63:32], 0);
      check("rst_cnt", busy_cnt, 0);
      check("rst_busy", rd_busy, 0);
      @(posedge clk); #1;
      preset_val = 32'h14;
      #1;
      check("rst_track", rd_data[31:0], 32'h14);
      @(posedge clk); #1;
      rst = 1;
      #1;
      check("rel_reg6", rd_data[31:0], 32'h14);

      for (int i = 0; i < 17; i++) begin
         wr0_en = v[i].w0e; wr0_addr = v[i].w0a; wr0_data = v[i].w0d;
         wr1_en = v[i].w1e; wr1_addr = v[i].w1a; wr1_data = v[i].w1d;
         rd_addr = {v[i].ra1, v[i].ra0};
         iss_en = v[i].ie; iss_addr = v[i].ia; flush = v[i].fl;
         @(negedge clk);
         check($sformatf("v%0d_d0", i), rd_data[31:0], v[i].ed0);
         check($sformatf("v%0d_d1", i), rd_data[63:32], v[i].ed1);
         check($sformatf("v%0d_busy", i), rd_busy, v[i].eb);
         @(posedge clk); #1;
         check($sformatf("v%0d_cnt", i), busy_cnt, v[i].ec);
      end

      idle();
      iss_en = 1; iss_addr = 10;
      @(posedge clk); #1;
      iss_addr = 11; wr0_en = 1; wr0_addr = 9; wr0_data = 32'h55;
      @(posedge clk); #1;
      idle();
      rd_addr = {5'd10, 5'd9};
      #1;
      check("pre_ar_cnt", busy_cnt, 2);
      check("pre_ar_reg9", rd_data[31:0], 32'h55);
      check("pre_ar_busy", rd_busy, 2'b10);
      #1;
      rst = 0;
      #1;
      check("ar_cnt", busy_cnt, 0);
      check("ar_reg9", rd_data[31:0], 0);
      check("ar_busy", rd_busy, 0);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      check("post_ar_reg9", rd_data[31:0], 0);
      check("post_ar_cnt", busy_cnt, 0);
      rd_addr = {5'd0, 5'd6};
      #1;
      check("post_ar_reg6", rd_data[31:0], 32'h14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
